// File: rtl/rr_arb_onehot_if.sv
// rr_arb_onehot_if -- handshake bundle for the round-robin one-hot arbiter.
//   v_vld/v_rdy/v_pld          : per-requester valid, ready and payload
//   out_vld/out_rdy/out_pld    : registered single-beat output stage
//   out_grant_onehot           : one-hot source index of the beat in out_pld
// Modports:
//   master : the environment (requesters + downstream sink)
//   slave  : the arbiter itself
interface rr_arb_onehot_if #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32
);
  logic [WIDTH-1:0]     v_vld;
  logic [WIDTH-1:0]     v_rdy;
  logic [PLD_WIDTH-1:0] v_pld [WIDTH-1:0];
  logic                 out_vld;
  logic                 out_rdy;
  logic [PLD_WIDTH-1:0] out_pld;
  logic [WIDTH-1:0]     out_grant_onehot;

  modport master (
    output v_vld, v_pld, out_rdy,
    input  v_rdy, out_vld, out_pld, out_grant_onehot
  );

  modport slave (
    input  v_vld, v_pld, out_rdy,
    output v_rdy, out_vld, out_pld, out_grant_onehot
  );
endinterface

// File: rtl/rr_arb_onehot.sv
// rr_arb_onehot -- round-robin arbiter with a one-hot grant and a registered
// single-entry output stage (1 beat/cycle sustained).
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : rr_arb_onehot_if.slave (requester side + output stage)
// The requester at or above the round-robin pointer with the lowest index
// wins; otherwise the lowest valid index wins (wrap). The pointer advances
// to winner+1 only on an accepted input beat.

// Per-requester slice: priority-window qualification and the AND term of
// the AND-OR payload mux.
module rr_arb_lane #(
  parameter int PLD_WIDTH = 32,
  parameter int PTR_W     = 2,
  parameter int IDX       = 0
) (
  input  logic                 vld,
  input  logic [PLD_WIDTH-1:0] pld,
  input  logic [PTR_W-1:0]     ptr,
  input  logic                 gnt,
  output logic                 hi_req,
  output logic [PLD_WIDTH-1:0] pld_term
);
  // Request sits in the "at or above ptr" window.
  assign hi_req   = vld & (PTR_W'(IDX) >= ptr);
  // Unselected payloads are forced to zero, so X on an idle lane never leaks.
  assign pld_term = pld & {PLD_WIDTH{gnt}};
endmodule

module rr_arb_onehot #(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  rr_arb_onehot_if.slave bus
);
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0]                 ptr_q, ptr_d;
  logic                             out_vld_q, out_vld_d;
  logic [PLD_WIDTH-1:0]             out_pld_q, out_pld_d;
  logic [WIDTH-1:0]                 out_gnt_q, out_gnt_d;

  logic [WIDTH-1:0]                 hi_req;
  logic [WIDTH-1:0]                 grant_hi, grant_lo, grant;
  logic [WIDTH-1:0][PLD_WIDTH-1:0]  pld_term;
  logic [PLD_WIDTH-1:0]             sel_pld;
  logic [PTR_W-1:0]                 gnt_idx, ptr_nxt;
  logic                             load, hs;
  logic [WIDTH-1:0]                 v_rdy;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    rr_arb_lane #(
      .PLD_WIDTH (PLD_WIDTH),
      .PTR_W     (PTR_W),
      .IDX       (i)
    ) u_lane (
      .vld      (bus.v_vld[i]),
      .pld      (bus.v_pld[i]),
      .ptr      (ptr_q),
      .gnt      (grant[i]),
      .hi_req   (hi_req[i]),
      .pld_term (pld_term[i])
    );
  end

  // Lowest set bit isolated with x & -x: first within the window, else
  // first overall (wrap). Result is one-hot or zero by construction.
  always_comb begin
    grant_hi = hi_req & (~hi_req + WIDTH'(1));
    grant_lo = bus.v_vld & (~bus.v_vld + WIDTH'(1));
    grant    = (|hi_req) ? grant_hi : grant_lo;
  end

  // AND-OR payload mux and one-hot -> binary for the pointer update.
  always_comb begin
    sel_pld = '0;
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel_pld = sel_pld | pld_term[i];
      if (grant[i]) gnt_idx = gnt_idx | PTR_W'(i);
    end
    ptr_nxt = (gnt_idx == PTR_W'(WIDTH - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Output stage is free when empty or draining this cycle. Ready is held
  // low during reset even though the stage reads as empty.
  always_comb begin
    load  = ~out_vld_q | bus.out_rdy;
    v_rdy = grant & {WIDTH{load & ~rst}};
    hs    = |(v_rdy & bus.v_vld);
  end

  always_comb begin
    out_vld_d = hs | (out_vld_q & ~bus.out_rdy);
    out_pld_d = hs ? sel_pld : out_pld_q;
    out_gnt_d = hs ? grant   : out_gnt_q;
    ptr_d     = hs ? ptr_nxt : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_pld_q <= '0;
      out_gnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_pld_q <= out_pld_d;
      out_gnt_q <= out_gnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.v_rdy            = v_rdy;
  assign bus.out_vld          = out_vld_q;
  assign bus.out_pld          = out_pld_q;
  assign bus.out_grant_onehot = out_gnt_q;
endmodule

// File: doc/rr_arb_onehot.md
RR_ARB_ONEHOT -- requirements
Module: rr_arb_onehot

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning number of requesters (>=2).
REQ-002 The block SHALL have parameter PLD_WIDTH, default 32, meaning payload bits per requester.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port v_vld, input, WIDTH, meaning per-requester valid.
REQ-006 The block SHALL have port v_rdy, output, WIDTH, meaning per-requester ready; at most one bit set.
REQ-007 The block SHALL have port v_pld, input, unpacked array [WIDTH-1:0] of PLD_WIDTH, meaning per-requester payload.
REQ-008 The block SHALL have port out_vld, output, 1, meaning registered output valid.
REQ-009 The block SHALL have port out_rdy, input, 1, meaning downstream ready.
REQ-010 The block SHALL have port out_pld, output, PLD_WIDTH, meaning registered winning payload.
REQ-011 The block SHALL have port out_grant_onehot, output, WIDTH, meaning registered one-hot index of the source of out_pld.

Function
REQ-012 Combinational grant SHALL be round-robin: the lowest index i with v_vld[i]=1 and i >= ptr; if none, the lowest index with v_vld[i]=1; all-zero if v_vld=0.
REQ-013 The grant SHALL be one-hot or zero in every cycle.
REQ-014 Payload selection SHALL be AND-OR over the one-hot grant: no priority encoder on the data path and no X-propagation from unselected payloads.
REQ-015 load = ~out_vld | out_rdy; v_rdy SHALL equal grant & {WIDTH{load}}.
REQ-016 An input handshake (v_vld[i] & v_rdy[i]) SHALL capture the payload into out_pld and the grant into out_grant_onehot and set out_vld=1 on the next edge; latency is 1 cycle.
REQ-017 If out_vld=1 & out_rdy=1 and no input handshake occurs, out_vld SHALL clear on the next edge; out_pld and out_grant_onehot SHALL hold their values.
REQ-018 Drain and load in the same cycle SHALL both complete: out_vld stays 1 with the new data, giving 1 beat/cycle sustained throughput.
REQ-019 If out_vld=1 & out_rdy=0, v_rdy SHALL be 0 and out_vld/out_pld/out_grant_onehot SHALL hold.
REQ-020 ptr (log2 WIDTH bits) SHALL update only on an input handshake, to (granted index + 1) mod WIDTH, wrapping WIDTH-1 -> 0.
REQ-021 ptr SHALL NOT change while stalled or while v_vld=0.
REQ-022 The grant MAY change between cycles while not handshaking (e.g. a new request at a higher-priority position); no grant lock is implied.
REQ-023 Upstream SHALL hold v_vld[i] and v_pld[i] stable until handshake; the block does not check this.
REQ-024 Fairness: with all WIDTH requesters continuously valid and out_rdy=1, each requester SHALL win exactly once per WIDTH consecutive beats.

Reset
REQ-025 While rst=1 (asserted asynchronously, released synchronously by the integrator): out_vld=0, out_pld=0, out_grant_onehot=0, ptr=0.
REQ-026 A beat held in the output register when rst asserts SHALL be discarded; v_rdy SHALL be 0 during reset.
REQ-027 After release, the first grant SHALL favour index 0.

Verification (WIDTH=4, PLD_WIDTH=32)
REQ-028 Reset, then v_vld=4'b1111, v_pld[i]=32'hA0+i, out_rdy=1 held -> out_pld sequence 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles starting 1 cycle after first handshake; out_grant_onehot 0001,0010,0100,1000,0001.
REQ-029 ptr=2, v_vld=4'b0011 -> grant 0001 (wrap), then ptr=1; next cycle grant 0010.
REQ-030 out_vld=1, out_rdy=0 for 5 cycles with v_vld=4'b0100 -> v_rdy=0, out_pld/out_grant_onehot/ptr unchanged; on out_rdy=1, same cycle v_rdy=4'b0100, next cycle new beat presented.
REQ-031 v_vld=0 and out_rdy=1 with out_vld=1 -> out_vld=0 next cycle, ptr unchanged, v_rdy=0.
REQ-032 rst asserted mid-stream with out_vld=1, out_pld=0xA2 -> out_vld=0, out_pld=0, out_grant_onehot=0 immediately (no clock edge needed); after release with v_vld=4'b1000, grant=1000.
REQ-033 Random v_vld/out_rdy for 10k cycles with a scoreboard -> no beat lost or duplicated, v_rdy and out_grant_onehot are always one-hot or zero, and no requester waits more than WIDTH beats while it stays valid.
